// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper.
package score_pkg;

  localparam int unsigned BCD_W = 4;

  // Three packed BCD digits: [2]=hundreds, [1]=tens, [0]=ones
  typedef logic [2:0][BCD_W-1:0] bcd3_t;

  localparam bcd3_t SCORE_MAX = 12'h999;

endpackage

// File: rtl/bcd_add_sat.sv
// Three-digit BCD adder: a + 1 (or + 2 when two is set), saturating at 999.
module bcd_add_sat
  import score_pkg::*;
(
  input  bcd3_t a,
  input  logic  two,
  output bcd3_t sum
);

  logic [BCD_W:0] d;
  logic [1:0]     c;
  bcd3_t          res;

  // Ripple the increment through the digits; a carry out of hundreds saturates
  always_comb begin
    d   = '0;
    res = '0;
    c   = two ? 2'd2 : 2'd1;
    for (int unsigned i = 0; i < 3; i++) begin
      d = {1'b0, a[i]} + (BCD_W+1)'(c);
      if (d > (BCD_W+1)'(9)) begin
        d = d - (BCD_W+1)'(10);
        c = 2'd1;
      end else begin
        c = 2'd0;
      end
      res[i] = d[BCD_W-1:0];
    end
    sum = (c != 2'd0) ? SCORE_MAX : res;
  end

endmodule

// File: rtl/score_keeper.sv
// Two-player BCD score keeper with frame-synchronous display registers.
// Optional combo (double points after STREAK_LEN consecutive hits) is
// enabled by defining SCORE_COMBO_EN.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned STREAK_LEN = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        clear,
  input  logic        p1_hit,
  input  logic        p2_hit,
  input  logic        p1_miss,
  input  logic        p2_miss,
  output logic [11:0] p1_digits,
  output logic [11:0] p2_digits,
  output logic        p1_full,
  output logic        p2_full
);

  logic [1:0] hit;
  logic [1:0] miss;
  logic [1:0] two;
  bcd3_t      work [2];
  bcd3_t      disp [2];
  bcd3_t      next [2];

  logic frame_clk_q;
  logic edge_block;
  logic frame_edge;

  assign hit  = {p2_hit, p1_hit};
  assign miss = {p2_miss, p1_miss};

  for (genvar g = 0; g < 2; g++) begin : g_player
    bcd_add_sat u_add (
      .a   (work[g]),
      .two (two[g]),
      .sum (next[g])
    );
  end

`ifdef SCORE_COMBO_EN
  localparam int unsigned STREAK_W = $clog2(STREAK_LEN + 1);

  logic [STREAK_W-1:0] streak [2];

  // Per-player streak: saturates at STREAK_LEN, any miss clears it
  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (Reset || clear) begin
        streak[i] <= '0;
      end else if (miss[i]) begin
        streak[i] <= '0;
      end else if (hit[i] && (streak[i] != STREAK_W'(STREAK_LEN))) begin
        streak[i] <= streak[i] + 1'b1;
      end
    end
  end

  // Double points once the streak preceding this hit has reached STREAK_LEN
  always_comb begin
    two = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      two[i] = (streak[i] == STREAK_W'(STREAK_LEN));
    end
  end
`else
  logic unused_streak_len;
  assign unused_streak_len = ^STREAK_LEN;

  // Single points only
  always_comb begin
    two = '0;
  end
`endif

  // edge_block suppresses the edge a frame_clk held high across reset release
  // would otherwise produce; it drops once frame_clk is seen low.
  assign frame_edge = frame_clk & ~frame_clk_q & ~edge_block;

  // Frame strobe synchroniser and post-reset edge mask
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_q <= 1'b0;
      edge_block  <= frame_clk;
    end else begin
      frame_clk_q <= frame_clk;
      edge_block  <= edge_block & frame_clk;
    end
  end

  // Working counters: clear beats hits; display captures pre-hit value
  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (Reset || clear) begin
        work[i] <= '0;
        disp[i] <= '0;
      end else begin
        if (hit[i]) begin
          work[i] <= next[i];
        end
        if (frame_edge) begin
          disp[i] <= work[i];
        end
      end
    end
  end

  assign p1_digits = disp[0];
  assign p2_digits = disp[1];
  assign p1_full   = (work[0] == SCORE_MAX);
  assign p2_full   = (work[1] == SCORE_MAX);

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper. Combo-dependent expectations follow
// SCORE_COMBO_EN.
module tb_score_keeper;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic        clear;
  logic        p1_hit, p2_hit, p1_miss, p2_miss;
  logic [11:0] p1_digits, p2_digits;
  logic        p1_full, p2_full;

  int n_tests = 0;
  int n_fail  = 0;

  score_keeper #(.STREAK_LEN(10)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .clear     (clear),
    .p1_hit    (p1_hit),
    .p2_hit    (p2_hit),
    .p1_miss   (p1_miss),
    .p2_miss   (p2_miss),
    .p1_digits (p1_digits),
    .p2_digits (p2_digits),
    .p1_full   (p1_full),
    .p2_full   (p2_full)
  );

  always #10 Clk = ~Clk;

`ifdef SCORE_COMBO_EN
  localparam logic [11:0] EXP_COMBO12 = 12'h014;
  localparam logic [11:0] EXP_COMBO13 = 12'h015;
  localparam logic [11:0] EXP_P2_11   = 12'h015;
`else
  localparam logic [11:0] EXP_COMBO12 = 12'h012;
  localparam logic [11:0] EXP_COMBO13 = 12'h013;
  localparam logic [11:0] EXP_P2_11   = 12'h014;
`endif

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse(input logic h1, input logic m1, input logic h2, input logic m2);
    p1_hit = h1; p1_miss = m1; p2_hit = h2; p2_miss = m2;
    tick();
    p1_hit = 1'b0; p1_miss = 1'b0; p2_hit = 1'b0; p2_miss = 1'b0;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; clear = 1'b0;
    p1_hit = 1'b0; p2_hit = 1'b0; p1_miss = 1'b0; p2_miss = 1'b0;
    tick();
    tick();
    check("rst_p1", p1_digits, 12'h000);
    check("rst_p2", p2_digits, 12'h000);
    check("rst_full1", {11'b0, p1_full}, 12'h000);
    check("rst_full2", {11'b0, p2_full}, 12'h000);
    Reset = 1'b0;

    // Five hits become visible only after a frame edge
    for (int i = 0; i < 5; i++) pulse(1, 0, 0, 0);
    check("no_frame", p1_digits, 12'h000);
    frame();
    check("five_p1", p1_digits, 12'h005);
    check("five_p2", p2_digits, 12'h000);

    // frame_clk held high: no second load
    frame_clk = 1'b1;
    tick();
    pulse(1, 0, 0, 0);
    tick();
    check("tear", p1_digits, 12'h005);
    frame_clk = 1'b0;
    tick();
    frame();
    check("six", p1_digits, 12'h006);

    // Hit coincident with the edge shows the pre-hit value first
    frame_clk = 1'b1; p1_hit = 1'b1;
    tick();
    frame_clk = 1'b0; p1_hit = 1'b0;
    check("edge_hit", p1_digits, 12'h006);
    tick();
    frame();
    check("edge_hit_next", p1_digits, 12'h007);

    // Hit+miss pairs always add exactly 1
    for (int i = 0; i < 92; i++) pulse(1, 1, 0, 0);
    frame();
    check("p1_099", p1_digits, 12'h099);
    pulse(1, 0, 0, 0);
    frame();
    check("p1_100", p1_digits, 12'h100);
    check("full_100", {11'b0, p1_full}, 12'h000);

    for (int i = 0; i < 899; i++) pulse(1, 1, 0, 0);
    check("full_999", {11'b0, p1_full}, 12'h001);
    frame();
    check("p1_999", p1_digits, 12'h999);
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
    check("full_sat", {11'b0, p1_full}, 12'h001);
    frame();
    check("p1_sat", p1_digits, 12'h999);
    check("p2_idle", p2_digits, 12'h000);
    check("p2_full_idle", {11'b0, p2_full}, 12'h000);

    // Mid-game reset with frame_clk held high across release
    frame_clk = 1'b1;
    do_reset();
    check("mid_rst_p1", p1_digits, 12'h000);
    check("mid_rst_full", {11'b0, p1_full}, 12'h000);
    pulse(1, 0, 0, 0);
    tick();
    check("no_edge_after_rst", p1_digits, 12'h000);
    frame_clk = 1'b0;
    tick();
    frame();
    check("after_rst_frame", p1_digits, 12'h001);

    // Simultaneous events on both players
    do_reset();
    for (int i = 0; i < 3; i++) pulse(1, 0, 1, 1);
    frame();
    check("sim_p1", p1_digits, 12'h003);
    check("sim_p2", p2_digits, 12'h003);
    for (int i = 0; i < 11; i++) pulse(0, 0, 1, 0);
    frame();
    check("p2_streak_cleared", p2_digits, EXP_P2_11);

    // Clear beats same-cycle hit and frame edge
    do_reset();
    for (int i = 0; i < 161; i++) pulse(1, 1, (i < 20), (i < 20));
    frame();
    check("pre_clr_p1", p1_digits, 12'h161);
    check("pre_clr_p2", p2_digits, 12'h020);
    clear = 1'b1; p1_hit = 1'b1; frame_clk = 1'b1;
    tick();
    clear = 1'b0; p1_hit = 1'b0; frame_clk = 1'b0;
    check("clr_p1", p1_digits, 12'h000);
    check("clr_p2", p2_digits, 12'h000);
    tick();
    frame();
    check("clr_work_p1", p1_digits, 12'h000);
    check("clr_work_p2", p2_digits, 12'h000);

    // Combo: 12 hits, then miss and one hit
    do_reset();
    for (int i = 0; i < 12; i++) pulse(1, 0, 0, 0);
    frame();
    check("combo12", p1_digits, EXP_COMBO12);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    frame();
    check("combo_miss_hit", p1_digits, EXP_COMBO13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
